// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider -- multi-cycle restoring integer divider.
//
// One shift-and-subtract step per clock; the borrow of the trial subtraction
// decides whether the partial remainder is restored or kept.  The execute
// stage stalls while busy is high and collects quotient/remainder on done.
//
// Build option: define DIV_SIGNED_EN for two's complement operands.  The
// magnitudes are divided, and a FIX state (one extra clock) then applies the
// signs.  Without it the divider is unsigned and FIX does not exist.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request pulse, accepted only while busy=0
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   busy         operation in progress (start ignored)
//   done         one-cycle pulse; results valid from this cycle on
//   quotient     result, held until the next accepted start completes
//   remainder    result, held until the next accepted start completes
//   div_by_zero  set with done when divisor was 0, held like the results
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
`ifdef DIV_SIGNED_EN
      FIX  = 2'd2,
`endif
      DONE = 2'd3
   } state_t;

   state_t          state_reg;
   logic [CW-1:0]   count_reg;
   logic [WIDTH-1:0] q_reg;      // dividend shifts out, quotient bits shift in
   logic [WIDTH-1:0] r_reg;      // partial remainder
   logic [WIDTH-1:0] d_reg;      // latched divisor (magnitude in signed build)
   logic             dz_reg;     // divisor was zero: skip the iterations

   // Operand magnitudes as they are loaded into the datapath.
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;

`ifdef DIV_SIGNED_EN
   logic sign_q_reg;
   logic sign_r_reg;

   // The most negative value maps to itself, which reads correctly as an
   // unsigned magnitude.
   assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
   assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
   assign dividend_mag = dividend;
   assign divisor_mag  = divisor;
`endif

   // One restoring step: shift the next dividend bit into the remainder and
   // try to subtract the divisor; the extra top bit is the borrow.
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH:0]   trial;
   logic             no_borrow;
   logic [WIDTH-1:0] r_step;
   logic [WIDTH-1:0] q_step;

   assign r_shift   = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
   assign trial     = {1'b0, r_shift} - {1'b0, d_reg};
   assign no_borrow = ~trial[WIDTH];
   assign r_step    = no_borrow ? trial[WIDTH-1:0] : r_shift;
   assign q_step    = {q_reg[WIDTH-2:0], no_borrow};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         count_reg   <= '0;
         q_reg       <= '0;
         r_reg       <= '0;
         d_reg       <= '0;
         dz_reg      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
         sign_q_reg  <= 1'b0;
         sign_r_reg  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE, DONE: begin
               // Accepting in DONE gives back-to-back operation; the old
               // results stay on the outputs until the new done.
               if (start) begin
                  d_reg     <= divisor_mag;
                  q_reg     <= dividend_mag;
                  r_reg     <= '0;
                  count_reg <= CW'(WIDTH - 1);
                  dz_reg    <= (divisor == '0);
                  busy      <= 1'b1;
                  state_reg <= CALC;
`ifdef DIV_SIGNED_EN
                  sign_q_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  sign_r_reg <= dividend[WIDTH-1];
`endif
               end
            end

            CALC: begin
               if (dz_reg) begin
                  // Divide by zero finishes one edge after acceptance.
                  // q_reg still holds the loaded dividend (magnitude when
                  // signed, so the dividend sign is reapplied).
                  quotient    <= '1;
`ifdef DIV_SIGNED_EN
                  remainder   <= sign_r_reg ? -q_reg : q_reg;
`else
                  remainder   <= q_reg;
`endif
                  div_by_zero <= 1'b1;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state_reg   <= DONE;
               end else begin
                  q_reg     <= q_step;
                  r_reg     <= r_step;
                  count_reg <= count_reg - CW'(1);
                  if (count_reg == '0) begin
`ifdef DIV_SIGNED_EN
                     state_reg <= FIX;
`else
                     // Publish the final step directly so done follows the
                     // last iteration with no extra cycle.
                     quotient    <= q_step;
                     remainder   <= r_step;
                     div_by_zero <= 1'b0;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     state_reg   <= DONE;
`endif
                  end
               end
            end

`ifdef DIV_SIGNED_EN
            FIX: begin
               // Remainder takes the dividend's sign (truncating division).
               quotient    <= sign_q_reg ? -q_reg : q_reg;
               remainder   <= sign_r_reg ? -r_reg : r_reg;
               div_by_zero <= 1'b0;
               busy        <= 1'b0;
               done        <= 1'b1;
               state_reg   <= DONE;
            end
`endif

            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider -- self-checking bench for seq_divider at WIDTH=8.
// A transaction-level model predicts busy/done/results from plain arithmetic
// and a latency count; it is compared against the DUT every falling edge.
// Directed operations also check literal, hand-computed results and latency.
// Build with DIV_SIGNED_EN defined to exercise the signed variant.
// -----------------------------------------------------------------------------
module tb_seq_divider;

   localparam int W = 8;
`ifdef DIV_SIGNED_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference division: returns {div_by_zero, quotient, remainder}.
   function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] q;
      logic [W-1:0] r;
      if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef DIV_SIGNED_EN
      if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) return {1'b0, a, {W{1'b0}}};
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
`else
      q = a / b;
      r = a % b;
`endif
      return {1'b0, q, r};
   endfunction

   // Transaction model: an accepted request stays busy for a fixed number of
   // edges, then publishes its reference result with a one-cycle done.
   logic         m_busy, m_done, m_dz, p_dz;
   logic [W-1:0] m_q, m_r, p_q, p_r;
   int           m_left;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_dz   <= 1'b0;
         m_q    <= '0;
         m_r    <= '0;
         m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_dz   <= p_dz;
               m_q    <= p_q;
               m_r    <= p_r;
            end
         end else if (start) begin
            m_busy <= 1'b1;
            m_left <= (divisor == '0) ? 1 : LAT;
            {p_dz, p_q, p_r} <= ref_div(dividend, divisor);
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en)
         chk("cycle {busy,done,dz,q,r}",
             64'({busy, done, div_by_zero, quotient, remainder}),
             64'({m_busy, m_done, m_dz, m_q, m_r}));
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Issue one operation at a falling edge and wait (bounded) for done.
   // poke pulses a competing start at E3, which must be ignored.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int lat, input bit poke,
                         input string name);
      int cyc;
      bit seen;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start    = 1'b0;
            dividend = W'($urandom);
            divisor  = W'($urandom);
            chk({name, " busy after accept"}, 64'(busy), 64'd1);
         end
         if (poke && cyc == 3) begin
            start    = 1'b1;
            dividend = 8'd7;
            divisor  = 8'd7;
         end
         if (poke && cyc == 4) start = 1'b0;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      if (!seen) begin
         chk({name, " done timeout"}, 64'd0, 64'd1);
      end else begin
         $display("op %s: %0d / %0d -> q=%0d r=%0d dz=%0d latency=%0d",
                  name, a, b, quotient, remainder, div_by_zero, cyc - 1);
         chk({name, " latency"}, 64'(cyc - 1), 64'(lat));
         chk({name, " quotient"}, 64'(quotient), 64'(eq));
         chk({name, " remainder"}, 64'(remainder), 64'(er));
         chk({name, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2*W:0] e;
      logic [W-1:0] ra, rb;

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      idle(2);
      cmp_en = 1'b1;
      chk("reset outputs", 64'({busy, done, div_by_zero, quotient, remainder}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT, 1'b0, "100/7");
      idle(2);
      run_op(8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 1, 1'b0, "200/0");
      idle(1);
      run_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, LAT, 1'b0, "9/3");
      idle(2);
      run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, LAT, 1'b1, "255/1 with ignored start");
      run_op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, LAT, 1'b0, "5/9 back-to-back");
      idle(2);
      run_op(8'd3, 8'd200, 8'd0, 8'd3, 1'b0, LAT, 1'b0, "3/200");
      idle(1);
      run_op(8'd0, 8'd5, 8'd0, 8'd0, 1'b0, LAT, 1'b0, "0/5");
      idle(1);
      run_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, LAT, 1'b0, "255/255");
      idle(2);

      // Asynchronous reset in the middle of the iterations (after E3).
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd7;
      @(negedge clk);
      start = 1'b0;
      idle(3);
      #2 rst_n = 1'b0;
      #1 chk("async reset outputs", 64'({busy, done, div_by_zero, quotient, remainder}), 64'd0);
      $display("op async reset mid-operation: busy=%0d done=%0d q=%0d r=%0d",
               busy, done, quotient, remainder);
      idle(2);
      rst_n = 1'b1;
      idle(3);
      run_op(8'd12, 8'd4, 8'd3, 8'd0, 1'b0, LAT, 1'b0, "12/4 after reset");
      idle(1);

`ifdef DIV_SIGNED_EN
      run_op(8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, LAT, 1'b0, "-7/2");
      idle(1);
      run_op(8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0, LAT, 1'b0, "7/-2");
      idle(1);
      run_op(8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, LAT, 1'b0, "-128/-1");
      idle(1);
`endif

      for (int i = 0; i < 300; i++) begin
         ra = W'($urandom);
         rb = (i % 16 == 0) ? 8'd0 : W'($urandom);
         e  = ref_div(ra, rb);
         run_op(ra, rb, e[2*W-1:W], e[W-1:0], e[2*W], (rb == '0) ? 1 : LAT, 1'b0, "random");
         if (i % 3 == 0) idle(1);
      end

      idle(2);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
